txt_load_sequencer: RTL

TXT_LOAD_SEQUENCER -- requirements
Module: txt_load_sequencer

---
 rtl/uk101_pkg.sv | 19 +
 rtl/sync_fifo.sv | 54 +++++
 rtl/txt_load_sequencer.sv | 121 ++++++++++++
 3 files changed

// File: rtl/uk101_pkg.sv
// Shared types and ASCII constants for the UK101 text-load path.
package uk101_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRESENT = 2'd1,
      ST_GAP     = 2'd2
   } state_t;

   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;
   localparam int         GAP_W    = 23;

   // LF becomes CR so BASIC sees a line end; the UK101 has no use for bit 7.
   function automatic logic [7:0] translate_byte(input logic [7:0] b);
      return (b == ASCII_LF) ? ASCII_CR : {1'b0, b[6:0]};
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with level output, flush, and same-cycle push/pop.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk_sys,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     empty,
   output logic                     full
);

   localparam int               AW       = $clog2(DEPTH);
   localparam logic [AW:0]      FULL_LVL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (level == '0);
   assign full    = (level == FULL_LVL);
   assign do_pop  = pop & ~empty;
   // A pop frees the slot in the same cycle, so a full FIFO still accepts.
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk_sys) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge clk_sys) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/txt_load_sequencer.sv
// Feeds an HPS text download into the UK101 serial receive path, one byte at
// a time with idle gaps so BASIC keeps up with typed-in program lines.
module txt_load_sequencer
   import uk101_pkg::*;
#(
   parameter int         CHAR_GAP   = 100_000,
   parameter int         LINE_GAP   = 5_000_000,
   parameter int         FIFO_DEPTH = 16,
   parameter logic [7:0] TXT_INDEX  = 8'd0
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        enable,
   input  logic        ioctl_download,
   input  logic        ioctl_wr,
   input  logic [7:0]  ioctl_index,
   input  logic [7:0]  ioctl_dout,
   output logic        ioctl_wait,
   output logic [7:0]  rx_data,
   output logic        rx_valid,
   input  logic        rx_ready,
   output logic        busy,
   output logic        overflow,
   output logic [15:0] byte_count
);

   localparam int               LW          = $clog2(FIFO_DEPTH) + 1;
   localparam logic [LW-1:0]    WAIT_LVL    = LW'(FIFO_DEPTH - 2);
   localparam logic [GAP_W-1:0] CHAR_RELOAD = GAP_W'(CHAR_GAP - 1);
   localparam logic [GAP_W-1:0] LINE_RELOAD = GAP_W'(LINE_GAP - 1);

   state_t           state;
   logic [GAP_W-1:0] gap_cnt;
   logic             dl_q;
   logic             prev_cr;
   logic             idx_match;
   logic             dl_start;
   logic             accept;
   logic             lf_drop;
   logic             push;
   logic             pop;
   logic [7:0]       fifo_dout;
   logic [LW-1:0]    fifo_level;
   logic             fifo_empty;
   logic             fifo_full;

   assign idx_match = (ioctl_index == TXT_INDEX);
   assign dl_start  = ioctl_download & ~dl_q & idx_match;
   assign accept    = ioctl_download & ioctl_wr & enable & idx_match;
   // The CR tracker is already considered cleared in the download-start cycle.
   assign lf_drop   = (ioctl_dout == ASCII_LF) & prev_cr & ~dl_start;
   assign push      = accept & ~lf_drop;
   assign pop       = (state == ST_PRESENT) & enable & rx_ready;

   assign rx_valid  = (state == ST_PRESENT) & enable;
   assign rx_data   = rx_valid ? fifo_dout : 8'h00;
   assign busy      = (ioctl_download & idx_match) | ~fifo_empty | (state != ST_IDLE);

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_sys (clk_sys),
      .reset   (reset),
      .flush   (~enable),
      .push    (push),
      .din     (translate_byte(ioctl_dout)),
      .pop     (pop),
      .dout    (fifo_dout),
      .level   (fifo_level),
      .empty   (fifo_empty),
      .full    (fifo_full)
   );

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         dl_q       <= 1'b0;
         prev_cr    <= 1'b0;
         overflow   <= 1'b0;
         byte_count <= '0;
         ioctl_wait <= 1'b0;
      end else begin
         dl_q       <= ioctl_download;
         // Lags the level by a cycle; the two spare slots absorb in-flight writes.
         ioctl_wait <= (fifo_level >= WAIT_LVL);
         if (accept)        prev_cr <= (ioctl_dout == ASCII_CR);
         else if (dl_start) prev_cr <= 1'b0;
         if (push && fifo_full && !pop) overflow <= 1'b1;
         else if (dl_start)             overflow <= 1'b0;
         if (dl_start) byte_count <= '0;
         else if (pop) byte_count <= byte_count + 16'd1;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state   <= ST_IDLE;
         gap_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (!fifo_empty && enable) state <= ST_PRESENT;
            end
            ST_PRESENT: begin
               if (!enable) begin
                  state <= ST_IDLE;
               end else if (rx_ready) begin
                  gap_cnt <= (fifo_dout == ASCII_CR) ? LINE_RELOAD : CHAR_RELOAD;
                  state   <= ST_GAP;
               end
            end
            ST_GAP: begin
               if (gap_cnt == '0) state <= (!fifo_empty && enable) ? ST_PRESENT : ST_IDLE;
               else               gap_cnt <= gap_cnt - 1'b1;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
